// File: rtl/binconv_multi.sv
// binconv_multi: streams binary images from an input SRAM, applies NUM_KERNELS
// 3x3 binary kernels per image and writes thresholded match maps to an output
// SRAM. Optional feature macro BINCONV_THRESH_EN: the match threshold is loaded
// from weight memory address 0 instead of being fixed at 5.
//
// state | meaning
// IDLE  | waiting for dut_run
// WLOAD | reading kernels (and threshold) from weight memory
// HDR   | reading an image header; terminator, skip or start image
// FILL  | loading image rows into the 3-row window
// OUT   | writing one output word for the current window
module binconv_multi #(
  parameter int MAX_DIM     = 16,
  parameter int NUM_KERNELS = 2
) (
  input  logic        clk,
  input  logic        reset_b,
  input  logic        dut_run,
  output logic        dut_busy,
  output logic [11:0] dut_sram_read_address,
  input  logic [15:0] sram_dut_read_data,
  output logic [11:0] dut_sram_write_address,
  output logic [15:0] dut_sram_write_data,
  output logic        dut_sram_write_enable,
  output logic [11:0] dut_wmem_read_address,
  input  logic [15:0] wmem_dut_read_data
);

  localparam int NPE = MAX_DIM - 2;
  localparam logic [2:0] LAST_K = 3'(NUM_KERNELS - 1);

`ifdef BINCONV_THRESH_EN
  localparam logic [11:0] WM_FIRST = 12'd0;
  logic [3:0] thresh;
`else
  localparam logic [11:0] WM_FIRST = 12'd1;
  logic [3:0] thresh;
  assign thresh = 4'd5;
`endif

  typedef enum logic [2:0] {IDLE, WLOAD, HDR, FILL, OUT} state_t;

  state_t      state;
  logic [1:0]  lat;        // read latency down-counter; data captured at 1
  logic [11:0] base;       // header address of the current image
  logic [11:0] wr_ptr;
  logic [4:0]  n_dim;
  logic [2:0]  kidx;
  logic [1:0]  fill_left;
  logic [3:0]  out_left;
  logic [15:0] row0, row1, row2;
  logic [8:0]  kern [8];

  logic [8:0]  cur_kern;
  logic [2:0]  wm_idx;
  logic [4:0]  hdr_n;
  logic [11:0] nxt_base;
  logic [NPE-1:0] pix;
  logic [15:0] out_word;
  logic        unused_wmem_bits;

  assign cur_kern         = kern[kidx];
  assign wm_idx           = 3'(dut_wmem_read_address - 12'd1);
  assign hdr_n            = sram_dut_read_data[4:0];
  assign nxt_base         = base + 12'(n_dim) + 12'd1;
  assign unused_wmem_bits = ^wmem_dut_read_data[15:9];

  function automatic logic [3:0] popcount9(input logic [8:0] v);
    logic [3:0] s;
    s = '0;
    for (int b = 0; b < 9; b++) s = s + {3'b000, v[b]};
    return s;
  endfunction

  // One PE per output column: XNOR window against kernel, popcount, threshold.
  for (genvar i = 0; i < NPE; i++) begin : g_pe
    logic [8:0] win;
    assign win    = {row2[i+2:i], row1[i+2:i], row0[i+2:i]};
    assign pix[i] = popcount9(~(win ^ cur_kern)) >= thresh;
  end

  // Keep only the N-2 valid pixels of the current output word.
  always_comb begin
    out_word = '0;
    for (int i = 0; i < NPE; i++) begin
      if (i < int'(n_dim) - 2) out_word[i] = pix[i];
    end
  end

  // Job sequencer with registered memory interfaces.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state                  <= IDLE;
      dut_busy               <= 1'b0;
      dut_sram_read_address  <= '0;
      dut_sram_write_address <= '0;
      dut_sram_write_data    <= '0;
      dut_sram_write_enable  <= 1'b0;
      dut_wmem_read_address  <= '0;
      lat                    <= '0;
      base                   <= '0;
      wr_ptr                 <= '0;
      n_dim                  <= '0;
      kidx                   <= '0;
      fill_left              <= '0;
      out_left               <= '0;
      row0                   <= '0;
      row1                   <= '0;
      row2                   <= '0;
      for (int j = 0; j < 8; j++) kern[j] <= '0;
`ifdef BINCONV_THRESH_EN
      thresh                 <= '0;
`endif
    end else begin
      dut_sram_write_enable <= 1'b0;
      case (state)
        IDLE: begin
          if (dut_run) begin
            dut_busy              <= 1'b1;
            base                  <= '0;
            wr_ptr                <= '0;
            dut_wmem_read_address <= WM_FIRST;
            lat                   <= 2'd2;
            state                 <= WLOAD;
          end
        end

        WLOAD: begin
          if (lat > 2'd1) begin
            lat <= lat - 2'd1;
          end else begin
`ifdef BINCONV_THRESH_EN
            if (dut_wmem_read_address == 12'd0) thresh <= wmem_dut_read_data[3:0];
            else kern[wm_idx] <= wmem_dut_read_data[8:0];
`else
            kern[wm_idx] <= wmem_dut_read_data[8:0];
`endif
            lat <= 2'd2;
            if (dut_wmem_read_address == 12'(NUM_KERNELS)) begin
              dut_sram_read_address <= base;
              state                 <= HDR;
            end else begin
              dut_wmem_read_address <= dut_wmem_read_address + 12'd1;
            end
          end
        end

        HDR: begin
          if (lat > 2'd1) begin
            lat <= lat - 2'd1;
          end else if (sram_dut_read_data[7:0] == 8'hFF) begin
            dut_busy <= 1'b0;
            lat      <= '0;
            state    <= IDLE;
          end else if (hdr_n < 5'd3 || hdr_n > 5'(MAX_DIM)) begin
            // Unsupported size: hop over the header and its rows.
            base                  <= base + 12'(hdr_n) + 12'd1;
            dut_sram_read_address <= base + 12'(hdr_n) + 12'd1;
            lat                   <= 2'd2;
          end else begin
            n_dim                 <= hdr_n;
            kidx                  <= '0;
            out_left              <= 4'(hdr_n - 5'd2);
            fill_left             <= 2'd3;
            dut_sram_read_address <= base + 12'd1;
            lat                   <= 2'd2;
            state                 <= FILL;
          end
        end

        FILL: begin
          if (lat > 2'd1) begin
            lat <= lat - 2'd1;
          end else begin
            row0 <= row1;
            row1 <= row2;
            row2 <= sram_dut_read_data;
            if (fill_left == 2'd1) begin
              lat   <= '0;
              state <= OUT;
            end else begin
              fill_left             <= fill_left - 2'd1;
              dut_sram_read_address <= dut_sram_read_address + 12'd1;
              lat                   <= 2'd2;
            end
          end
        end

        OUT: begin
          dut_sram_write_enable  <= 1'b1;
          dut_sram_write_address <= wr_ptr;
          dut_sram_write_data    <= out_word;
          wr_ptr                 <= wr_ptr + 12'd1;
          lat                    <= 2'd2;
          if (out_left == 4'd1) begin
            if (kidx == LAST_K) begin
              base                  <= nxt_base;
              dut_sram_read_address <= nxt_base;
              state                 <= HDR;
            end else begin
              // Each kernel re-reads the image from its first row.
              kidx                  <= kidx + 3'd1;
              out_left              <= 4'(n_dim - 5'd2);
              fill_left             <= 2'd3;
              dut_sram_read_address <= base + 12'd1;
              state                 <= FILL;
            end
          end else begin
            out_left              <= out_left - 4'd1;
            fill_left             <= 2'd1;
            dut_sram_read_address <= dut_sram_read_address + 12'd1;
            state                 <= FILL;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_binconv_multi.sv
// Scoreboard bench for binconv_multi (default MAX_DIM=16, NUM_KERNELS=2).
module tb_binconv_multi;

  localparam int MAXD = 16;
  localparam int NK   = 2;

  logic        clk;
  logic        reset_b;
  logic        dut_run;
  logic        dut_busy;
  logic [11:0] dut_sram_read_address;
  logic [15:0] sram_dut_read_data;
  logic [11:0] dut_sram_write_address;
  logic [15:0] dut_sram_write_data;
  logic        dut_sram_write_enable;
  logic [11:0] dut_wmem_read_address;
  logic [15:0] wmem_dut_read_data;

  logic [15:0] sram [0:4095];
  logic [15:0] wmem [0:15];
  logic [27:0] exp_q [$];
  logic [27:0] mon_ent;
  int          n_checks = 0;
  int          n_errors = 0;
  int          wp;

  binconv_multi #(.MAX_DIM(MAXD), .NUM_KERNELS(NK)) u_dut (
    .clk                    (clk),
    .reset_b                (reset_b),
    .dut_run                (dut_run),
    .dut_busy               (dut_busy),
    .dut_sram_read_address  (dut_sram_read_address),
    .sram_dut_read_data     (sram_dut_read_data),
    .dut_sram_write_address (dut_sram_write_address),
    .dut_sram_write_data    (dut_sram_write_data),
    .dut_sram_write_enable  (dut_sram_write_enable),
    .dut_wmem_read_address  (dut_wmem_read_address),
    .wmem_dut_read_data     (wmem_dut_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered memories: data appears one cycle after the address.
  always @(posedge clk) begin
    sram_dut_read_data <= sram[dut_sram_read_address];
    wmem_dut_read_data <= wmem[dut_wmem_read_address[3:0]];
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Every write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (reset_b && dut_sram_write_enable) begin
      check_val("wr_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_ent = exp_q.pop_front();
        check_val("wr_addr", 32'(dut_sram_write_address), 32'(mon_ent[27:16]));
        check_val("wr_data", 32'(dut_sram_write_data), 32'(mon_ent[15:0]));
      end
    end
  end

  // kind 0: all ones, 1: checkerboard, 2: random rows
  task automatic put_img(input int n, input int kind);
    sram[wp % 4096] = 16'(n);
    for (int r = 1; r <= n; r++) begin
      if (kind == 0)      sram[(wp + r) % 4096] = 16'hFFFF;
      else if (kind == 1) sram[(wp + r) % 4096] = (r % 2 == 1) ? 16'h5555 : 16'hAAAA;
      else                sram[(wp + r) % 4096] = 16'($urandom);
    end
    wp = wp + n + 1;
  endtask

  task automatic put_term();
    sram[wp % 4096] = 16'h00FF;
  endtask

  task automatic push_const(input int first, input int count, input logic [15:0] val);
    for (int j = 0; j < count; j++) exp_q.push_back({12'(first + j), val});
  endtask

  // Reference: walk the input memory exactly as the job description defines.
  task automatic model_job();
    int base, wa, thr, n, m;
    logic [15:0] h, word, rw;
    base = 0;
    wa   = 0;
`ifdef BINCONV_THRESH_EN
    thr = int'(wmem[0][3:0]);
`else
    thr = 5;
`endif
    for (int g = 0; g < 200; g++) begin
      h = sram[base % 4096];
      if (h[7:0] == 8'hFF) break;
      n = int'(h[4:0]);
      if (n >= 3 && n <= MAXD) begin
        for (int k = 0; k < NK; k++) begin
          for (int t = 0; t <= n - 3; t++) begin
            word = '0;
            for (int i = 0; i <= n - 3; i++) begin
              m = 0;
              for (int r = 0; r < 3; r++) begin
                rw = sram[(base + 1 + t + r) % 4096];
                for (int c = 0; c < 3; c++) if (wmem[k + 1][3 * r + c] == rw[i + c]) m++;
              end
              if (m >= thr) word[i] = 1'b1;
            end
            exp_q.push_back({12'(wa % 4096), word});
            wa++;
          end
        end
      end
      base = base + n + 1;
    end
  endtask

  task automatic run_job(input string tag);
    int cyc;
    @(posedge clk); #1 dut_run = 1'b1;
    @(posedge clk); #1 dut_run = 1'b0;
    check_val({tag, "_busy_rise"}, 32'(dut_busy), 32'd1);
    // A start request while busy must be ignored.
    repeat (2) @(posedge clk);
    #1 dut_run = 1'b1;
    @(posedge clk); #1 dut_run = 1'b0;
    cyc = 0;
    while (dut_busy && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    check_val({tag, "_done_in_time"}, 32'(dut_busy), 32'd0);
    repeat (4) @(negedge clk);
    check_val({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    check_val({tag, "_stays_idle"}, 32'(dut_busy), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, cyc;
    for (int a = 0; a < 4096; a++) sram[a] = '0;
    for (int a = 0; a < 16; a++) wmem[a] = '0;
    wmem[0]  = 16'd5;
    reset_b  = 1'b0;
    dut_run  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_busy", 32'(dut_busy), 32'd0);
    check_val("rst_we", 32'(dut_sram_write_enable), 32'd0);
    check_val("rst_rd_addr", 32'(dut_sram_read_address), 32'd0);
    check_val("rst_wr_addr", 32'(dut_sram_write_address), 32'd0);
    check_val("rst_wm_addr", 32'(dut_wmem_read_address), 32'd0);
    reset_b = 1'b1;

    // N=10 all ones, both kernels all ones
    wp = 0; put_img(10, 0); put_term();
    wmem[1] = 16'h01FF; wmem[2] = 16'h01FF;
    push_const(0, 16, 16'h00FF);
    run_job("n10_ones");

    // N=16 all ones, kernels all ones then all zeros
    wp = 0; put_img(16, 0); put_term();
    wmem[1] = 16'h01FF; wmem[2] = 16'h0000;
    push_const(0, 14, 16'h3FFF);
    push_const(14, 14, 16'h0000);
    run_job("n16_two_k");

    // Threshold boundary: 5 matches -> 1, 4 matches -> 0
    wp = 0; put_img(3, 0); put_term();
    wmem[1] = 16'h001F; wmem[2] = 16'h000F;
    push_const(0, 1, 16'h0001);
    push_const(1, 1, 16'h0000);
    run_job("match5_vs_4");

    // Two images back to back; second header at address 13
    wp = 0; put_img(12, 2); put_img(10, 2); put_term();
    wmem[1] = 16'($urandom_range(0, 511)); wmem[2] = 16'h01FF;
    model_job();
    check_val("two_img_count", 32'(exp_q.size()), 32'd36);
    run_job("two_images");

    // Invalid sizes are skipped without writes
    wp = 0; put_img(0, 2); put_img(2, 2); put_img(20, 2); put_img(5, 2); put_term();
    wmem[1] = 16'($urandom_range(0, 511)); wmem[2] = 16'($urandom_range(0, 511));
    model_job();
    check_val("skip_count", 32'(exp_q.size()), 32'd6);
    run_job("skip_bad_n");

    // Checkerboard with the matching kernel and a random one
    wp = 0; put_img(16, 1); put_term();
    wmem[1] = 16'h00AA; wmem[2] = 16'($urandom_range(0, 511));
    model_job();
    run_job("checker");

    for (int j = 0; j < 3; j++) begin
      wp = 0;
      put_img(int'($urandom_range(3, 16)), 2);
      put_img(int'($urandom_range(3, 16)), 2);
      put_term();
      wmem[1] = 16'($urandom_range(0, 511)); wmem[2] = 16'($urandom_range(0, 511));
      model_job();
      run_job("random");
    end

    // Reset asserted right after the third write
    wp = 0; put_img(16, 1); put_term();
    wmem[1] = 16'h00AA; wmem[2] = 16'($urandom_range(0, 511));
    model_job();
    @(posedge clk); #1 dut_run = 1'b1;
    @(posedge clk); #1 dut_run = 1'b0;
    cnt = 0;
    cyc = 0;
    while (cnt < 3 && cyc < 5000) begin
      @(negedge clk);
      cyc++;
      if (dut_sram_write_enable) cnt++;
    end
    check_val("abort_third_write", 32'(cnt), 32'd3);
    #1 reset_b = 1'b0;
    #1;
    check_val("abort_we", 32'(dut_sram_write_enable), 32'd0);
    check_val("abort_busy", 32'(dut_busy), 32'd0);
    check_val("abort_wr_addr", 32'(dut_sram_write_address), 32'd0);
    check_val("abort_rd_addr", 32'(dut_sram_read_address), 32'd0);
    exp_q.delete();
    @(posedge clk); #1 reset_b = 1'b1;
    model_job();
    run_job("rerun");

`ifdef BINCONV_THRESH_EN
    // One mismatching kernel bit per window: 8 matches everywhere
    wp = 0; put_img(8, 0); put_term();
    wmem[1] = 16'h01FE; wmem[2] = 16'h01FE;
    wmem[0] = 16'd9;
    push_const(0, 12, 16'h0000);
    run_job("thresh9");
    wmem[0] = 16'd0;
    push_const(0, 12, 16'h003F);
    run_job("thresh0");
    wmem[0] = 16'd5;
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
